uart_boot_loader: RTL and testbench
===================================

Name: uart_boot_loader

Overview:
- Sits between the UART pair (UartRx/UartTx) and the core in `top`.
- Owns the UART during boot:
  - announces itself with 0x99;
  - receives a 4-byte little-endian program size;
  - receives the program bytes and assembles them into 32-bit words;
  - writes the words to instruction memory;
  - announces completion with 0xaa.
- After boot, hands the UART to the core through a TX arbiter port and an RX byte FIFO.

Parameters:
- IMEM_ADDR_W, 14, word-address width of the instruction memory write port; capacity is 2**IMEM_ADDR_W words.
- RX_FIFO_DEPTH, 16, depth of the RUN-phase receive FIFO; power of two, at least 2.

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- rx_ready  in  1  UartRx one-cycle strobe: byte available
- rdata  in  8  UartRx byte
- ferr  in  1  UartRx framing error, valid with rx_ready
- tx_start  out  1  UartTx start pulse
- sdata  out  8  UartTx byte
- tx_busy  in  1  UartTx busy
- imem_we  out  1  instruction memory write enable
- imem_addr  out  IMEM_ADDR_W  word address
- imem_wdata  out  32  word data, little-endian assembled
- boot_done  out  1  high once in RUN; core held until then
- boot_err  out  1  sticky: framing error or size overflow during boot
- cpu_tx_valid  in  1  core requests to send cpu_tx_data
- cpu_tx_data  in  8  byte from core
- cpu_tx_ready  out  1  byte accepted this cycle
- cpu_rx_valid  out  1  FIFO not empty
- cpu_rx_data  out  8  FIFO head
- cpu_rx_pop  in  1  core consumes head
- rx_overflow  out  1  sticky: byte dropped in RUN because FIFO full

Behaviour:
- Reset (async assert, sync deassert use):
  - all outputs 0;
  - state SEND_SYNC;
  - byte counter, word address, size register and FIFO pointers cleared.
- A reset mid-operation aborts any phase and restarts from SEND_SYNC. Instruction memory contents are not touched.
- TX issue rule (all states): tx_start is a one-cycle pulse, asserted only when tx_busy==0 and tx_start was 0 in the previous cycle. This covers the one-cycle tx_busy lag. sdata is registered with tx_start and held until the next issue.
- States:
  - SEND_SYNC: issue 0x99, then go to RECV_SIZE.
  - RECV_SIZE: on each rx_ready, shift rdata into the size register, LSB first. After the 4th byte:
    - words = size>>2; any remainder 1-3 bytes is received and discarded;
    - if size==0, go to SEND_READY, else go to RECV_PROG.
  - RECV_PROG: assemble 4 bytes LSB-first.
    - On the 4th byte, imem_we=1 for exactly one cycle (1 cycle after that rx_ready), with the current address and word; then the address increments.
    - After the last byte, go to SEND_READY.
    - Words whose address is at or beyond 2**IMEM_ADDR_W are not written (no wrap-around) and set boot_err.
  - SEND_READY: issue 0xaa, then go to RUN with boot_done=1 from the next cycle.
  - RUN: terminal until reset.
    - cpu_tx_ready = TX issue rule satisfied. A byte transfers when cpu_tx_valid && cpu_tx_ready, producing tx_start the next cycle with that byte.
    - Each rx_ready byte is pushed into the FIFO. If the FIFO is full, the byte is dropped and rx_overflow is set.
    - Push and pop in the same cycle while full: the pop frees the slot and the push succeeds.
    - Pop while empty is ignored.
- ferr during boot: the byte is still consumed and counted, and boot_err is set. In RUN, ferr bytes are pushed normally.
- rx_ready outside RECV_SIZE, RECV_PROG and RUN is ignored.
- cpu_tx_ready=0 and cpu_rx_valid=0 before RUN.

Optional Feature:
- BOOT_CHECKSUM_EN defined:
  - the loader keeps a running XOR over all program bytes received in RECV_PROG, including the discarded tail;
  - SEND_READY first issues the checksum byte, then 0xaa (two bytes, TX issue rule between them).
- Undefined: only 0xaa is sent.

Decomposition:
- Package uart_boot_pkg:
  - state enum (SEND_SYNC, RECV_SIZE, RECV_PROG, SEND_READY, RUN);
  - SYNC_BYTE=8'h99;
  - READY_BYTE=8'haa.
- Sub-module byte_fifo:
  - parameter DEPTH;
  - ports clock, resetn, push, din, pop, dout, empty, full;
  - registered pointers with an extra wrap bit.

Test Plan:
- After reset, the UART model sees 0x99 once → it sends 08 00 00 00 then 13 00 00 00 6f 00 00 00 → imem writes addr0=0x00000013 and addr1=0x0000006f; tx 0xaa follows; boot_done=1.
- Size 00 00 00 00 → no imem_we; 0xaa issued immediately after the 4th size byte.
- Size 6 with bytes 01 02 03 04 05 06 → one write, addr0=0x04030201; bytes 05 and 06 discarded; then 0xaa. With BOOT_CHECKSUM_EN, 0x07 is sent before 0xaa.
- IMEM_ADDR_W=1, size 12 → addr0 and addr1 written, third word suppressed, boot_err=1, 0xaa still sent.
- In RUN, push 17 bytes 0x00..0x10 with no pop (depth 16) → rx_overflow=1, head=0x00; 16 pops return 0x00..0x0f in order.
- In RUN, cpu_tx_valid held with 0x41 then 0x42 → two tx_start pulses, each only after tx_busy falls, never on consecutive cycles. Assert resetn mid-byte → outputs 0 and 0x99 re-sent.

Source files
------------

// File: rtl/uart_boot_pkg.sv
// ============================================================
// uart_boot_pkg: shared states and protocol bytes for the UART boot loader.
// Revision: 1.0
// ============================================================
`default_nettype none

package uart_boot_pkg;

  typedef enum logic [2:0] {
    SEND_SYNC  = 3'd0,
    RECV_SIZE  = 3'd1,
    RECV_PROG  = 3'd2,
    SEND_READY = 3'd3,
    RUN        = 3'd4
  } boot_state_t;

  localparam logic [7:0] SYNC_BYTE  = 8'h99;
  localparam logic [7:0] READY_BYTE = 8'haa;

endpackage

`default_nettype wire

// File: rtl/uart_boot_loader_byte_fifo.sv
// ============================================================
// byte_fifo: byte FIFO with wrap-bit pointers; pop frees a slot for a same-cycle push.
// Revision: 1.0
// ============================================================
`default_nettype none

module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [7:0]  mem [DEPTH];
  logic        do_pop;
  logic        do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/uart_boot_loader.sv
// ============================================================
// uart_boot_loader: loads a program over UART into instruction memory, then
// shares the UART with the core. Macro BOOT_CHECKSUM_EN adds an XOR checksum byte.
// Revision: 1.0
// ============================================================
`default_nettype none

module uart_boot_loader
  import uart_boot_pkg::*;
#(
  parameter int IMEM_ADDR_W   = 14,
  parameter int RX_FIFO_DEPTH = 16
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   rx_ready,
  input  logic [7:0]             rdata,
  input  logic                   ferr,
  output logic                   tx_start,
  output logic [7:0]             sdata,
  input  logic                   tx_busy,
  output logic                   imem_we,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  output logic [31:0]            imem_wdata,
  output logic                   boot_done,
  output logic                   boot_err,
  input  logic                   cpu_tx_valid,
  input  logic [7:0]             cpu_tx_data,
  output logic                   cpu_tx_ready,
  output logic                   cpu_rx_valid,
  output logic [7:0]             cpu_rx_data,
  input  logic                   cpu_rx_pop,
  output logic                   rx_overflow
);
  boot_state_t            state;
  logic [31:0]            size_q;
  logic [31:0]            byte_cnt;
  logic [23:0]            word_q;
  logic [1:0]             size_idx;
  logic [IMEM_ADDR_W-1:0] wr_addr;
  logic                   addr_full;
  logic                   can_issue;
  logic [31:0]            size_next;
  logic [31:0]            word_next;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_empty;
  logic                   fifo_full;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]             cksum;
  logic                   ck_sent;
`endif

  // tx_start is registered, so its current value is last cycle's issue
  assign can_issue    = !tx_busy && !tx_start;
  assign size_next    = {rdata, size_q[31:8]};
  assign word_next    = {rdata, word_q};
  assign cpu_tx_ready = (state == RUN) && can_issue;
  assign cpu_rx_valid = !fifo_empty;
  assign fifo_push    = (state == RUN) && rx_ready;
  assign fifo_pop     = (state == RUN) && cpu_rx_pop;

  byte_fifo #(.DEPTH(RX_FIFO_DEPTH)) u_rx_fifo (
    .clock  (clock),
    .resetn (resetn),
    .push   (fifo_push),
    .din    (rdata),
    .pop    (fifo_pop),
    .dout   (cpu_rx_data),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= SEND_SYNC;
      tx_start    <= 1'b0;
      sdata       <= 8'h00;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= 32'h0;
      boot_done   <= 1'b0;
      boot_err    <= 1'b0;
      rx_overflow <= 1'b0;
      size_q      <= 32'h0;
      byte_cnt    <= 32'h0;
      word_q      <= 24'h0;
      size_idx    <= 2'd0;
      wr_addr     <= '0;
      addr_full   <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      cksum       <= 8'h00;
      ck_sent     <= 1'b0;
`endif
    end else begin
      tx_start <= 1'b0;
      imem_we  <= 1'b0;
      if (rx_ready && ferr && (state == RECV_SIZE || state == RECV_PROG)) boot_err <= 1'b1;

      case (state)
        SEND_SYNC: begin
          if (can_issue) begin
            tx_start <= 1'b1;
            sdata    <= SYNC_BYTE;
            state    <= RECV_SIZE;
          end
        end
        RECV_SIZE: begin
          if (rx_ready) begin
            size_q   <= size_next;
            size_idx <= size_idx + 2'd1;
            if (size_idx == 2'd3) state <= (size_next == 32'h0) ? SEND_READY : RECV_PROG;
          end
        end
        RECV_PROG: begin
          if (rx_ready) begin
            word_q   <= word_next[31:8];
            byte_cnt <= byte_cnt + 32'd1;
`ifdef BOOT_CHECKSUM_EN
            cksum    <= cksum ^ rdata;
`endif
            // a trailing partial word never reaches lane 3, so it is dropped
            if (byte_cnt[1:0] == 2'd3) begin
              if (addr_full) begin
                boot_err <= 1'b1;
              end else begin
                imem_we    <= 1'b1;
                imem_addr  <= wr_addr;
                imem_wdata <= word_next;
                wr_addr    <= wr_addr + IMEM_ADDR_W'(1);
                if (&wr_addr) addr_full <= 1'b1;
              end
            end
            if (byte_cnt == size_q - 32'd1) state <= SEND_READY;
          end
        end
        SEND_READY: begin
          if (can_issue) begin
            tx_start <= 1'b1;
`ifdef BOOT_CHECKSUM_EN
            if (!ck_sent) begin
              sdata   <= cksum;
              ck_sent <= 1'b1;
            end else begin
              sdata     <= READY_BYTE;
              state     <= RUN;
              boot_done <= 1'b1;
            end
`else
            sdata     <= READY_BYTE;
            state     <= RUN;
            boot_done <= 1'b1;
`endif
          end
        end
        RUN: begin
          if (cpu_tx_valid && cpu_tx_ready) begin
            tx_start <= 1'b1;
            sdata    <= cpu_tx_data;
          end
          if (rx_ready && fifo_full && !cpu_rx_pop) rx_overflow <= 1'b1;
        end
        default: state <= SEND_SYNC;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_boot_loader.sv
// ============================================================
// tb_uart_boot_loader: randomized self-checking bench for uart_boot_loader.
// Revision: 1.0
// ============================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_boot_loader;
  localparam int AW    = 3;
  localparam int DEPTH = 16;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic rx_ready = 1'b0;
  logic [7:0] rdata = 8'h00;
  logic ferr = 1'b0;
  logic tx_busy;
  logic cpu_tx_valid = 1'b0;
  logic [7:0] cpu_tx_data = 8'h00;
  logic cpu_rx_pop = 1'b0;

  logic          tx_start;
  logic [7:0]    sdata;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          boot_done;
  logic          boot_err;
  logic          cpu_tx_ready;
  logic          cpu_rx_valid;
  logic [7:0]    cpu_rx_data;
  logic          rx_overflow;

  uart_boot_loader #(.IMEM_ADDR_W(AW), .RX_FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .resetn(resetn), .rx_ready(rx_ready), .rdata(rdata), .ferr(ferr),
    .tx_start(tx_start), .sdata(sdata), .tx_busy(tx_busy),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .boot_done(boot_done), .boot_err(boot_err),
    .cpu_tx_valid(cpu_tx_valid), .cpu_tx_data(cpu_tx_data), .cpu_tx_ready(cpu_tx_ready),
    .cpu_rx_valid(cpu_rx_valid), .cpu_rx_data(cpu_rx_data), .cpu_rx_pop(cpu_rx_pop),
    .rx_overflow(rx_overflow)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  // reference model state
  logic [7:0]    exp_tx[$];
  bit            exp_tx_last[$];
  logic [AW+31:0] exp_wr[$];
  logic [7:0]    fq[$];
  logic [7:0]    popped[$];
  logic [7:0]    tx_log[$];
  logic [7:0]    prog[$];
  logic [31:0]   mem_seen [2**AW];
  bit exp_ovf, exp_run, exp_err, must_start, cur_we, m_we;
  bit prev_start, prev_busy, busy_lag;
  int busy_cnt, acc_cnt, wr_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: checks outputs just after each negedge, then advances the model to the next posedge.
  initial begin
    tx_busy = 1'b0;
    acc_cnt = 0;
    wr_cnt  = 0;
    exp_err = 1'b0;
    forever begin
      @(negedge clock);
      #2;
      if (!resetn) begin
        chk("reset_outputs", {tx_start, sdata, imem_we, imem_addr, imem_wdata, boot_done, boot_err,
                              cpu_tx_ready, cpu_rx_valid, cpu_rx_data, rx_overflow}, 64'h0);
        fq.delete(); exp_tx.delete(); exp_tx_last.delete(); exp_wr.delete();
        exp_ovf = 0; exp_run = 0; must_start = 0; m_we = 0;
        prev_start = 0; prev_busy = 0; busy_lag = 0; busy_cnt = 0;
        tx_busy = 1'b0;
      end else begin
        if (must_start) chk("tx_after_accept", tx_start, 1);
        if (tx_start) begin
          chk("tx_issue_rule", {prev_start, prev_busy}, 0);
          tx_log.push_back(sdata);
          if (exp_tx.size() == 0) chk("tx_expected_count", exp_tx.size(), 1);
          else begin
            chk("tx_byte", sdata, exp_tx[0]);
            if (exp_tx_last[0]) exp_run = 1;
            void'(exp_tx.pop_front());
            void'(exp_tx_last.pop_front());
          end
        end
        chk("boot_done", boot_done, exp_run);
        chk("imem_we", imem_we, m_we);
        if (imem_we) begin
          if (exp_wr.size() == 0) chk("imem_wr_count", exp_wr.size(), 1);
          else chk("imem_write", {imem_addr, imem_wdata}, exp_wr.pop_front());
          mem_seen[imem_addr] = imem_wdata;
          wr_cnt++;
        end
        if (exp_run) chk("boot_err", boot_err, exp_err);
        chk("cpu_tx_ready", cpu_tx_ready, exp_run && !tx_busy && !tx_start);
        chk("cpu_rx_valid", cpu_rx_valid, fq.size() > 0);
        if (fq.size() > 0) chk("cpu_rx_data", cpu_rx_data, fq[0]);
        chk("rx_overflow", rx_overflow, exp_ovf);

        // UART transmitter: busy goes high one cycle after it sees tx_start
        prev_start = tx_start;
        if (busy_lag) begin
          tx_busy  = 1'b1;
          busy_cnt = $urandom_range(5, 1);
          busy_lag = 0;
        end else if (busy_cnt > 0) begin
          busy_cnt--;
          if (busy_cnt == 0) tx_busy = 1'b0;
        end
        if (tx_start) busy_lag = 1;
        prev_busy = tx_busy;

        must_start = 0;
        if (exp_run && cpu_tx_valid && !tx_busy && !tx_start) begin
          exp_tx.push_back(cpu_tx_data);
          exp_tx_last.push_back(0);
          must_start = 1;
          acc_cnt++;
        end
        m_we = rx_ready && cur_we;
        if (exp_run) begin
          if (cpu_rx_pop && fq.size() > 0) begin
            popped.push_back(cpu_rx_data);
            void'(fq.pop_front());
          end
          if (rx_ready) begin
            if (fq.size() < DEPTH) fq.push_back(rdata);
            else exp_ovf = 1;
          end
        end
      end
    end
  end

  task automatic do_reset();
    #3 resetn = 1'b0;
    rx_ready = 0; ferr = 0; cur_we = 0; cpu_tx_valid = 0; cpu_rx_pop = 0;
    repeat (3) @(negedge clock);
    exp_tx.push_back(8'h99);
    exp_tx_last.push_back(0);
    exp_err = 0;
    tx_log.delete();
    resetn = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit fe, input bit we);
    @(negedge clock);
    rx_ready = 1; rdata = b; ferr = fe; cur_we = we;
    @(negedge clock);
    rx_ready = 0; ferr = 0; cur_we = 0;
    repeat ($urandom_range(2, 0)) @(negedge clock);
  endtask

  task automatic wait_tx_drain(input string name, input int budget);
    int n = 0;
    while (exp_tx.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk(name, exp_tx.size(), 0);
  endtask

  task automatic push_ready(input logic [7:0] ck);
`ifdef BOOT_CHECKSUM_EN
    exp_tx.push_back(ck);
    exp_tx_last.push_back(0);
`else
    if (ck === 8'hxx) $display("unreachable");
`endif
    exp_tx.push_back(8'haa);
    exp_tx_last.push_back(1);
  endtask

  // Sends size + prog[0..size-1]; expectations follow from the boot protocol arithmetic.
  task automatic boot(input logic [31:0] size, input bit rand_ferr);
    logic [7:0] ck = 8'h00;
    logic [31:0] w;
    bit fe, we;
    int n = 0;
    wait_tx_drain("sync_sent", 60);
    for (int i = 0; i < 4; i++) begin
      fe = rand_ferr && ($urandom_range(7, 0) == 0);
      if (fe) exp_err = 1;
      if (i == 3 && size == 0) push_ready(ck);
      send_byte(size[8*i +: 8], fe, 0);
    end
    for (int i = 0; i < int'(size); i++) begin
      ck ^= prog[i];
      we = 0;
      if (i % 4 == 3) begin
        if (i / 4 < 2**AW) begin
          w = {prog[i], prog[i-1], prog[i-2], prog[i-3]};
          exp_wr.push_back({AW'(i / 4), w});
          we = 1;
        end else exp_err = 1;
      end
      fe = rand_ferr && ($urandom_range(15, 0) == 0);
      if (fe) exp_err = 1;
      if (i == int'(size) - 1) push_ready(ck);
      send_byte(prog[i], fe, we);
    end
    while (!exp_run && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("reached_run", exp_run, 1);
    chk("boot_err_final", boot_err, exp_err);
    chk("writes_drained", exp_wr.size(), 0);
  endtask

  task automatic cpu_send(input logic [7:0] b);
    int a = acc_cnt;
    int n = 0;
    @(negedge clock);
    cpu_tx_valid = 1; cpu_tx_data = b;
    while (acc_cnt == a && n < 100) begin
      @(negedge clock);
      n++;
    end
    cpu_tx_valid = 0;
    chk("cpu_tx_accept", acc_cnt, a + 1);
  endtask

  task automatic traffic(input int nbytes, input int ntx, input int npop);
    fork
      for (int i = 0; i < nbytes; i++) send_byte(8'($urandom), $urandom_range(3, 0) == 0, 0);
      for (int i = 0; i < ntx; i++) cpu_send(8'($urandom));
      begin
        for (int i = 0; i < npop; i++) begin
          @(negedge clock);
          cpu_rx_pop = $urandom_range(1, 0) == 1;
        end
        @(negedge clock);
        cpu_rx_pop = 0;
      end
    join
    wait_tx_drain("traffic_tx_drain", 60);
  endtask

  task automatic set_prog(input int n);
    prog.delete();
    for (int i = 0; i < n; i++) prog.push_back(8'($urandom));
  endtask

  initial begin
    int w0;
    int sz;
    repeat (3) @(negedge clock);
    exp_tx.push_back(8'h99);
    exp_tx_last.push_back(0);
    resetn = 1'b1;

    // two-word program
    prog = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h6f, 8'h00, 8'h00, 8'h00};
    boot(32'd8, 0);
    chk("lit_word0", mem_seen[0], 32'h00000013);
    chk("lit_word1", mem_seen[1], 32'h0000006f);
    chk("lit_boot_done", boot_done, 1);

    cpu_send(8'h41);
    cpu_send(8'h42);
    wait_tx_drain("cpu_tx_drain", 60);

    // fill the RX FIFO past capacity, then drain it
    for (int v = 0; v <= 16; v++) send_byte(8'(v), 0, 0);
    chk("lit_overflow", rx_overflow, 1);
    chk("lit_head", cpu_rx_data, 8'h00);
    popped.delete();
    @(negedge clock);
    cpu_rx_pop = 1;
    repeat (16) @(negedge clock);
    cpu_rx_pop = 0;
    @(negedge clock);
    chk("lit_pop_count", popped.size(), 16);
    for (int i = 0; i < 16 && i < popped.size(); i++) chk("lit_pop_order", popped[i], 8'(i));
    chk("lit_empty_after", cpu_rx_valid, 0);
    // pop while empty is ignored
    cpu_rx_pop = 1;
    repeat (2) @(negedge clock);
    cpu_rx_pop = 0;
    traffic(24, 4, 60);

    // reset while a byte is in flight
    cpu_send(8'h55);
    do_reset();
    wait_tx_drain("resync_sent", 60);
    chk("lit_resync", tx_log.size() > 0 ? tx_log[0] : 8'h00, 8'h99);

    // empty program
    w0 = wr_cnt;
    boot(32'd0, 0);
    chk("lit_size0_writes", wr_cnt - w0, 0);
`ifdef BOOT_CHECKSUM_EN
    chk("lit_size0_txlen", tx_log.size(), 3);
`else
    chk("lit_size0_txlen", tx_log.size(), 2);
`endif
    chk("lit_size0_last", tx_log[tx_log.size()-1], 8'haa);

    // size 6: one word, two tail bytes discarded
    do_reset();
    prog = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    w0 = wr_cnt;
    boot(32'd6, 0);
    chk("lit_size6_writes", wr_cnt - w0, 1);
    chk("lit_size6_word", mem_seen[0], 32'h04030201);
`ifdef BOOT_CHECKSUM_EN
    chk("lit_size6_ck", tx_log.size() == 3 ? tx_log[1] : 8'h00, 8'h07);
`endif
    chk("lit_size6_last", tx_log[tx_log.size()-1], 8'haa);

    // program larger than imem: 10 words into 8
    do_reset();
    set_prog(40);
    w0 = wr_cnt;
    boot(32'd40, 0);
    chk("lit_big_writes", wr_cnt - w0, 8);
    chk("lit_big_err", boot_err, 1);
    chk("lit_big_last", tx_log[tx_log.size()-1], 8'haa);

    for (int r = 0; r < 5; r++) begin
      do_reset();
      sz = $urandom_range(37, 0);
      set_prog(sz);
      boot(32'(sz), r % 2 == 1);
      traffic(10, 3, 30);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
